// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: tracks in-flight register writers, selects EX operand
// forwarding sources and raises an active-low stall for hazards it cannot forward.
module hazard_forward_unit #(
   parameter int REG_ADDR_W  = 3,
   parameter int NUM_SRC     = 2,
   parameter int DEPTH       = 3,
   parameter int FWD_EN      = 1,
   parameter int ZERO_REG_EN = 1,
   parameter int WB_BYPASS   = 1,
   parameter int SEL_W       = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          dec_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_src_addr,
   input  logic [NUM_SRC-1:0]            dec_src_used,
   input  logic                          dec_wb_en,
   input  logic [REG_ADDR_W-1:0]         dec_dest,
   input  logic                          dec_is_load,
   input  logic                          flush,
   output logic                          pipeline_stall_n,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
   output logic [15:0]                   stall_count
);

   localparam bit FWD_ON    = (FWD_EN != 0);
   localparam bit ZERO_ON   = (ZERO_REG_EN != 0);
   // The write-back entry needs no action when the register file writes before it reads.
   localparam int MATCH_MAX = (WB_BYPASS != 0) ? DEPTH - 1 : DEPTH;

   // Scoreboard: entry k holds the writer currently k stages past decode.
   logic [DEPTH:1]          ent_valid;
   logic [DEPTH:1]          ent_load;
   logic [REG_ADDR_W-1:0]   ent_dest [1:DEPTH];

   logic [SEL_W-1:0]        young_sel [NUM_SRC];
   logic                    any_match;
   logic                    load_use;
   logic                    dest_is_zero;

   // NOTE: combinational blocks use blocking assignments and give every output a
   // default first, so no path through the block leaves a latch behind.
   always_comb begin
      any_match = 1'b0;
      load_use  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [REG_ADDR_W-1:0] src;
         src          = dec_src_addr[i*REG_ADDR_W +: REG_ADDR_W];
         young_sel[i] = '0;
         // Walk from oldest to youngest so the lowest matching stage wins.
         for (int k = MATCH_MAX; k >= 1; k--) begin
            if (dec_valid && dec_src_used[i] && ent_valid[k] &&
                (ent_dest[k] == src) && !(ZERO_ON && (src == '0))) begin
               young_sel[i] = SEL_W'(k);
            end
         end
         if (young_sel[i] != '0) begin
            any_match = 1'b1;
            if ((young_sel[i] == SEL_W'(1)) && ent_load[1]) begin
               load_use = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pipeline_stall_n = FWD_ON ? !load_use : !any_match;
      fwd_sel          = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (FWD_ON && pipeline_stall_n) begin
            fwd_sel[i*SEL_W +: SEL_W] = young_sel[i];
         end
      end
   end

   assign dest_is_zero = ZERO_ON && (dec_dest == '0);

   // NOTE: the scoreboard is a handful of flops, so every field (dest included) is
   // reset along with the valids; state updates use non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ent_valid   <= '0;
         ent_load    <= '0;
         stall_count <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            ent_dest[k] <= '0;
         end
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            ent_valid[k] <= ent_valid[k-1];
            ent_load[k]  <= ent_load[k-1];
            ent_dest[k]  <= ent_dest[k-1];
         end
         // A stalled or flushed decode leaves a bubble behind in EX.
         ent_valid[1] <= dec_valid && dec_wb_en && pipeline_stall_n && !flush && !dest_is_zero;
         ent_load[1]  <= dec_is_load;
         ent_dest[1]  <= dec_dest;
         if (!pipeline_stall_n && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default forwarding build, a legacy
// stall-only build, and a deep stall-only build used to saturate stall_count.
module tb_hazard_forward_unit;

   logic       clock;
   logic       reset;
   logic       dec_valid;
   logic [5:0] dec_src_addr;
   logic [1:0] dec_src_used;
   logic       dec_wb_en;
   logic [2:0] dec_dest;
   logic       dec_is_load;
   logic       flush;

   logic        stall_n, lg_stall_n, sat_stall_n;
   logic [3:0]  fwd_sel, lg_fwd_sel;
   logic [7:0]  sat_fwd_sel;
   logic [15:0] stall_count, lg_stall_count, sat_stall_count;

   int checks = 0;
   int errors = 0;

   hazard_forward_unit dut (
      .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_src_addr(dec_src_addr),
      .dec_src_used(dec_src_used), .dec_wb_en(dec_wb_en), .dec_dest(dec_dest),
      .dec_is_load(dec_is_load), .flush(flush), .pipeline_stall_n(stall_n),
      .fwd_sel(fwd_sel), .stall_count(stall_count)
   );

   hazard_forward_unit #(.FWD_EN(0)) dut_lg (
      .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_src_addr(dec_src_addr),
      .dec_src_used(dec_src_used), .dec_wb_en(dec_wb_en), .dec_dest(dec_dest),
      .dec_is_load(dec_is_load), .flush(flush), .pipeline_stall_n(lg_stall_n),
      .fwd_sel(lg_fwd_sel), .stall_count(lg_stall_count)
   );

   hazard_forward_unit #(.DEPTH(15), .SEL_W(4), .FWD_EN(0), .WB_BYPASS(0)) dut_sat (
      .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_src_addr(dec_src_addr),
      .dec_src_used(dec_src_used), .dec_wb_en(dec_wb_en), .dec_dest(dec_dest),
      .dec_is_load(dec_is_load), .flush(flush), .pipeline_stall_n(sat_stall_n),
      .fwd_sel(sat_fwd_sel), .stall_count(sat_stall_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_dec(input logic v, input logic [2:0] s0, input logic u0,
                          input logic [2:0] s1, input logic u1, input logic wb,
                          input logic [2:0] dst, input logic ld);
      dec_valid    = v;
      dec_src_addr = {s1, s0};
      dec_src_used = {u1, u0};
      dec_wb_en    = wb;
      dec_dest     = dst;
      dec_is_load  = ld;
      flush        = 1'b0;
   endtask

   task automatic drain();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      checks++; if (stall_n !== 1'b1) begin errors++; $display("FAIL reset_stall_n got %b want 1", stall_n); end
      checks++; if (fwd_sel !== 4'd0) begin errors++; $display("FAIL reset_fwd_sel got %h want 0", fwd_sel); end
      checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_count); end
      reset = 1'b1;
      tick();
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL idle got stall_n=%b fwd=%h want 1/0", stall_n, fwd_sel); end
   endtask

   task automatic test_alu_chain();
      drain();
      set_dec(1, 2, 1, 3, 1, 1, 1, 0);   // R1 <- R2+R3
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL alu_first got stall_n=%b fwd=%h want 1/0", stall_n, fwd_sel); end
      tick();
      set_dec(1, 1, 1, 1, 1, 1, 4, 0);   // R4 <- R1+R1
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'b0101) begin
         errors++; $display("FAIL alu_ex_fwd got stall_n=%b fwd=%h want 1/5", stall_n, fwd_sel); end
      drain();
      set_dec(1, 2, 1, 3, 1, 1, 1, 0);
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_dec(1, 1, 1, 1, 1, 1, 4, 0);
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'b1010) begin
         errors++; $display("FAIL alu_mem_fwd got stall_n=%b fwd=%h want 1/a", stall_n, fwd_sel); end
   endtask

   task automatic test_load_use();
      drain();
      set_dec(1, 7, 0, 0, 0, 1, 2, 1);   // LW R2
      tick();
      set_dec(1, 2, 1, 6, 1, 1, 5, 0);   // ADD R5 <- R2+R6
      #1;
      checks++; if (stall_n !== 1'b0 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL load_use_stall got stall_n=%b fwd=%h want 0/0", stall_n, fwd_sel); end
      tick();
      #1;
      checks++; if (stall_n !== 1'b1) begin errors++; $display("FAIL load_use_release got %b want 1", stall_n); end
      checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL load_use_fwd got %h want 2", fwd_sel); end
      checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count got %0d want 1", stall_count); end
      tick();
   endtask

   task automatic test_youngest();
      drain();
      set_dec(1, 7, 0, 0, 0, 1, 3, 1);   // LW R3 (ends up in MEM)
      tick();
      set_dec(1, 2, 1, 2, 1, 1, 3, 0);   // R3 <- R2+R2 (in EX)
      tick();
      set_dec(1, 3, 1, 3, 0, 1, 6, 0);
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'b0001) begin
         errors++; $display("FAIL youngest got stall_n=%b fwd=%h want 1/1", stall_n, fwd_sel); end
      drain();
      set_dec(1, 2, 1, 2, 1, 1, 0, 1);   // LW R0
      tick();
      set_dec(1, 0, 1, 0, 1, 1, 5, 0);
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL zero_reg got stall_n=%b fwd=%h want 1/0", stall_n, fwd_sel); end
      checks++; if (lg_stall_n !== 1'b1) begin errors++; $display("FAIL zero_reg_legacy got %b want 1", lg_stall_n); end
   endtask

   task automatic test_legacy();
      drain();
      set_dec(1, 2, 1, 3, 1, 1, 1, 0);   // R1 <- R2+R3
      #1;
      checks++; if (lg_stall_n !== 1'b1) begin errors++; $display("FAIL legacy_first got %b want 1", lg_stall_n); end
      tick();
      set_dec(1, 1, 1, 0, 0, 1, 4, 0);   // reads R1
      #1;
      checks++; if (lg_stall_n !== 1'b0 || lg_fwd_sel !== 4'd0) begin
         errors++; $display("FAIL legacy_ex got stall_n=%b fwd=%h want 0/0", lg_stall_n, lg_fwd_sel); end
      checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_build_ex got %h want 1", fwd_sel); end
      tick();
      #1;
      checks++; if (lg_stall_n !== 1'b0) begin errors++; $display("FAIL legacy_mem got %b want 0", lg_stall_n); end
      tick();
      #1;
      checks++; if (lg_stall_n !== 1'b1) begin errors++; $display("FAIL legacy_wb_bypass got %b want 1", lg_stall_n); end
   endtask

   task automatic test_flush();
      drain();
      set_dec(1, 2, 1, 3, 1, 1, 4, 0);
      flush = 1'b1;
      #1;
      checks++; if (stall_n !== 1'b1) begin errors++; $display("FAIL flush_stall got %b want 1", stall_n); end
      tick();
      set_dec(1, 4, 1, 4, 1, 1, 5, 0);
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL flush_no_match got stall_n=%b fwd=%h want 1/0", stall_n, fwd_sel); end
      checks++; if (lg_stall_n !== 1'b1) begin errors++; $display("FAIL flush_legacy got %b want 1", lg_stall_n); end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      set_dec(1, 7, 0, 0, 0, 1, 2, 1);   // LW R2
      tick();
      set_dec(1, 2, 1, 6, 1, 1, 5, 0);
      #1;
      checks++; if (stall_n !== 1'b0) begin errors++; $display("FAIL mid_stall_pre got %b want 0", stall_n); end
      reset = 1'b0;
      #1;
      checks++; if (stall_n !== 1'b1 || stall_count !== 16'd0) begin
         errors++; $display("FAIL mid_stall_reset got stall_n=%b count=%0d want 1/0", stall_n, stall_count); end
      reset = 1'b1;
      #1;
      tick();
      #1;
      checks++; if (stall_n !== 1'b1 || fwd_sel !== 4'd0) begin
         errors++; $display("FAIL post_release got stall_n=%b fwd=%h want 1/0", stall_n, fwd_sel); end
   endtask

   task automatic test_saturate();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #2;
      // Self-dependent R1 writer: one issue then 15 stall cycles while it drains.
      set_dec(1, 1, 1, 0, 0, 1, 1, 0);
      reset = 1'b1;
      repeat (16) tick();
      #1;
      checks++; if (sat_stall_count !== 16'd15) begin errors++; $display("FAIL sat_period got %0d want 15", sat_stall_count); end
      repeat (70100 - 16) tick();
      #1;
      checks++; if (sat_stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h want ffff", sat_stall_count); end
      repeat (5) tick();
      checks++; if (sat_stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", sat_stall_count); end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_youngest();
      test_legacy();
      test_flush();
      test_reset_mid_stall();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the fixed 3-bit, 2-source stall-only hazard detector in the 16-bit five-stage pipeline.
- Keeps its own scoreboard of in-flight register writers, one entry per stage downstream of decode (EX, MEM, WB by default).
- Produces a per-source forwarding select and an active-low stall, so stalls are limited to true load-use cases when forwarding is enabled.
- Sits beside ID. It drives the IF enable, the IF/ID enable, the ID/EX bubble insertion and the EX operand muxes.

Parameters:
- REG_ADDR_W, 3, register address width.
- NUM_SRC, 2, number of decode source operands checked.
- DEPTH, 3, number of scoreboard entries. Entry k = stage k after ID (1=EX, 2=MEM, 3=WB).
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any match (legacy behaviour).
- ZERO_REG_EN, 1, 1 = register 0 is hardwired zero and never creates a hazard.
- WB_BYPASS, 1, 1 = register file writes before reads, so an entry-DEPTH match needs no action.
- SEL_W, 2, forwarding select width. Must satisfy 2^SEL_W > DEPTH.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- dec_valid, input, 1, the decode stage holds a real instruction.
- dec_src_addr, input, NUM_SRC*REG_ADDR_W, source addresses; source i occupies bits [i*REG_ADDR_W +: REG_ADDR_W].
- dec_src_used, input, NUM_SRC, bit i = source i is actually read.
- dec_wb_en, input, 1, the decoding instruction writes a register.
- dec_dest, input, REG_ADDR_W, destination of the decoding instruction.
- dec_is_load, input, 1, the decoding instruction is a memory load.
- flush, input, 1, kill the decoding instruction (taken branch or jump).
- pipeline_stall_n, output, 1, 0 = hold IF/IF-ID and insert an ID/EX bubble.
- fwd_sel, output, NUM_SRC*SEL_W, per-source select. 0 = register file; k = result of the stage-k entry.
- stall_count, output, 16, saturating count of stall cycles.

Behaviour:
- Scoreboard: DEPTH entries, each {valid, dest, is_load}. All entries shift every clock: entry k+1 <= entry k. The entry leaving position DEPTH is discarded.
- Entry 1 (EX) load rule:
  - Loaded with {1, dec_dest, dec_is_load} when dec_valid & dec_wb_en & pipeline_stall_n & !flush.
  - When ZERO_REG_EN=1 and dec_dest==0, valid is forced to 0.
  - In every other case entry 1 is loaded with a bubble (valid=0).
- Match: source i matches entry k when dec_valid, dec_src_used[i], entry k valid, and entry k dest equals the source address.
  - With ZERO_REG_EN=1, a source address of 0 never matches.
  - With WB_BYPASS=1, entry DEPTH is excluded from matching.
- Youngest wins: when several entries match, the lowest k is used.
- fwd_sel (combinational):
  - FWD_EN=1: value k of the youngest match, or 0 if there is no match.
  - FWD_EN=0: always 0.
  - Forced to 0 for a source while pipeline_stall_n=0.
- pipeline_stall_n (combinational), driven to 0 when:
  - FWD_EN=0: any source has any match.
  - FWD_EN=1: some source's youngest match is entry 1 with is_load=1 (load-use).
  - Otherwise it is 1.
- A load-use case stalls exactly 1 cycle. The bubble moves the load to entry 2, and the next cycle forwards from MEM with fwd_sel=2.
- flush has priority over stall when updating entry 1: a bubble is inserted.
  - pipeline_stall_n is still evaluated from the current decode inputs.
  - The upstream flush logic discards the held instruction.
- stall_count: increments on every clock with pipeline_stall_n=0 and saturates at 16'hFFFF.
- Reset (asynchronous, reset=0):
  - All entries go invalid and stall_count goes to 0.
  - Outputs then settle to pipeline_stall_n=1 and fwd_sel=0.
  - Reset asserted mid-stall clears the scoreboard immediately; there is no stall after release.
- No combinational path from stall_count to the other outputs. The scoreboard is the only state apart from stall_count.

Test Plan:
- Reset, then idle: pipeline_stall_n=1, fwd_sel=0, stall_count=0. After asserting reset mid-load-use, the first post-release cycle has pipeline_stall_n=1.
- ALU chain R1<-R2+R3, then R4<-R1+R1 (FWD_EN=1): no stall, fwd_sel={2'd1,2'd1}. One intervening bubble gives fwd_sel={2'd2,2'd2}.
- LW R2, then ADD R5<-R2+R6: pipeline_stall_n=0 for exactly 1 cycle. Next cycle fwd_sel[0]=2, fwd_sel[1]=0, and stall_count=1.
- Youngest wins: R3 written at MEM and at EX, decode reads R3 -> fwd_sel=1. Decode reading R0 with a pending write to R0 -> no match, no stall.
- FWD_EN=0 rebuild: ALU chain R1 then read R1 -> stall for 2 cycles (EX, then MEM). No stall when WB holds R1 and WB_BYPASS=1.
- Flush with dec_wb_en=1, dec_dest=4: the next decode reading R4 sees no match. stall_count driven by 65540 forced stall cycles saturates at 16'hFFFF.
